// File: rtl/micro_sequencer.sv
// Microprogram sequencer: registers the control-store address and computes the next one
// from the current microword's sequencing op, with a return stack, abort and IRQ vectoring.
module micro_sequencer #(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned FAMILY_W    = 16,
  parameter int unsigned DISPATCH_SH = 3,
  parameter int unsigned N_COND      = 8,
  parameter int unsigned STACK_DEPTH = 2,
  parameter int unsigned FETCH_ADDR  = 104,
  parameter int unsigned UNDEF_ADDR  = 104,
  parameter int unsigned IRQ_ADDR    = 112,
  parameter int unsigned ABORT_ADDR  = 120,
  parameter int unsigned ERR_ADDR    = 127,
  localparam int unsigned CondSelW   = (N_COND > 1) ? $clog2(N_COND) : 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [2:0]          seq_op_i,
  input  logic [ADDR_W-1:0]   j_field_i,
  input  logic [CondSelW-1:0] cond_sel_i,
  input  logic                cond_inv_i,
  input  logic [N_COND-1:0]   cond_vec_i,
  input  logic                evcond_i,
  input  logic [FAMILY_W-1:0] family_bits_i,
  input  logic                mem_ready_i,
  input  logic                stall_i,
  input  logic                abort_i,
  input  logic                irq_i,
  output logic [ADDR_W-1:0]   uaddr_o,
  output logic                at_fetch_o,
  output logic                irq_ack_o,
  output logic                ustack_err_o
);

  localparam int unsigned SpW = $clog2(STACK_DEPTH + 1);

  typedef enum logic [2:0] {
    OpNext, OpJump, OpCbr, OpDisp, OpCall, OpRet, OpWait, OpFetch
  } seq_op_e;

  logic [ADDR_W-1:0] uaddr_q, uaddr_d;
  logic [SpW-1:0]    sp_q, sp_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
  logic              irq_ack_q, irq_ack_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] disp_addr;
  logic [ADDR_W-1:0] top;
  logic              cpass;

  always_comb begin
    inc   = uaddr_q + 1'b1;
    cpass = cond_vec_i[cond_sel_i] ^ cond_inv_i;

    // Scan from the top down so the lowest set family bit wins.
    disp_addr = ADDR_W'(UNDEF_ADDR);
    for (int i = FAMILY_W - 1; i >= 0; i--) begin
      if (family_bits_i[i]) disp_addr = ADDR_W'(i << DISPATCH_SH);
    end

    top = stack_q[0];
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SpW'(i + 1)) top = stack_q[i];
    end
  end

  always_comb begin
    uaddr_d   = uaddr_q;
    sp_d      = sp_q;
    stack_d   = stack_q;
    irq_ack_d = 1'b0;
    err_d     = err_q;

    if (stall_i) begin
      uaddr_d = uaddr_q;
    end else if (abort_i) begin
      uaddr_d = ADDR_W'(ABORT_ADDR);
      sp_d    = '0;
    end else begin
      case (seq_op_e'(seq_op_i))
        OpNext: uaddr_d = inc;
        OpJump: uaddr_d = j_field_i;
        OpCbr:  uaddr_d = cpass ? j_field_i : inc;
        OpDisp: uaddr_d = evcond_i ? disp_addr : ADDR_W'(FETCH_ADDR);
        OpCall: begin
          if (sp_q < SpW'(STACK_DEPTH)) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
              if (sp_q == SpW'(i)) stack_d[i] = inc;
            end
            sp_d    = sp_q + 1'b1;
            uaddr_d = j_field_i;
          end else begin
            err_d   = 1'b1;
            uaddr_d = ADDR_W'(ERR_ADDR);
          end
        end
        OpRet: begin
          if (sp_q != '0) begin
            uaddr_d = top;
            sp_d    = sp_q - 1'b1;
          end else begin
            err_d   = 1'b1;
            uaddr_d = ADDR_W'(ERR_ADDR);
          end
        end
        OpWait: uaddr_d = mem_ready_i ? inc : uaddr_q;
        OpFetch: begin
          if (irq_i) begin
            uaddr_d   = ADDR_W'(IRQ_ADDR);
            irq_ack_d = 1'b1;
          end else begin
            uaddr_d = ADDR_W'(FETCH_ADDR);
          end
        end
        default: uaddr_d = inc;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      uaddr_q   <= ADDR_W'(FETCH_ADDR);
      sp_q      <= '0;
      irq_ack_q <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      uaddr_q   <= uaddr_d;
      sp_q      <= sp_d;
      irq_ack_q <= irq_ack_d;
      err_q     <= err_d;
      stack_q   <= stack_d;
    end
  end

  assign uaddr_o      = uaddr_q;
  assign at_fetch_o   = (uaddr_q == ADDR_W'(FETCH_ADDR));
  assign irq_ack_o    = irq_ack_q;
  assign ustack_err_o = err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: each step pushes the expected post-edge state into a
// scoreboard queue, which is popped and compared one time unit after the edge.
module tb_micro_sequencer;

  localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, CBR = 3'd2, DISP = 3'd3;
  localparam logic [2:0] CALL = 3'd4, RET = 3'd5, WAIT = 3'd6, FETCH = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  seq_op;
  logic [6:0]  j_field;
  logic [2:0]  cond_sel;
  logic        cond_inv;
  logic [7:0]  cond_vec;
  logic        evcond;
  logic [15:0] family_bits;
  logic        mem_ready;
  logic        stall;
  logic        abort;
  logic        irq;
  logic [6:0]  uaddr;
  logic        at_fetch;
  logic        irq_ack;
  logic        ustack_err;

  always #5 clk = ~clk;

  micro_sequencer dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .seq_op_i      (seq_op),
    .j_field_i     (j_field),
    .cond_sel_i    (cond_sel),
    .cond_inv_i    (cond_inv),
    .cond_vec_i    (cond_vec),
    .evcond_i      (evcond),
    .family_bits_i (family_bits),
    .mem_ready_i   (mem_ready),
    .stall_i       (stall),
    .abort_i       (abort),
    .irq_i         (irq),
    .uaddr_o       (uaddr),
    .at_fetch_o    (at_fetch),
    .irq_ack_o     (irq_ack),
    .ustack_err_o  (ustack_err)
  );

  typedef struct {
    string      tag;
    logic [6:0] ua;
    logic       ack;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic e_err  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one microword, advance one edge, then compare against the queued expectation.
  task automatic step(input string tag, input logic [2:0] op, input logic [6:0] j,
                      input logic [6:0] eu, input logic eack);
    exp_t e;
    seq_op  = op;
    j_field = j;
    sb.push_back('{tag: tag, ua: eu, ack: eack, err: e_err});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".uaddr"}, 32'(uaddr), 32'(e.ua));
    chk({e.tag, ".at_fetch"}, 32'(at_fetch), 32'(e.ua == 7'd104));
    chk({e.tag, ".irq_ack"}, 32'(irq_ack), 32'(e.ack));
    chk({e.tag, ".err"}, 32'(ustack_err), 32'(e.err));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    e_err = 1'b0;
    chk("reset.uaddr", 32'(uaddr), 32'd104);
    chk("reset.at_fetch", 32'(at_fetch), 32'd1);
    chk("reset.irq_ack", 32'(irq_ack), 32'd0);
    chk("reset.err", 32'(ustack_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    seq_op = NEXT; j_field = '0; cond_sel = '0; cond_inv = 1'b0; cond_vec = '0;
    evcond = 1'b1; family_bits = '0; mem_ready = 1'b0; stall = 1'b0; abort = 1'b0;
    irq = 1'b0; reset = 1'b0;
    #2;
    do_reset();

    // Straight-line sequencing and jump back to fetch.
    step("next1", NEXT, 7'd0, 7'd105, 1'b0);
    step("next2", NEXT, 7'd0, 7'd106, 1'b0);
    step("jump0", JUMP, 7'd0, 7'd0, 1'b0);
    step("fetch", FETCH, 7'd0, 7'd104, 1'b0);

    // Dispatch: lowest set family bit selects the target.
    family_bits = 16'h0030;
    step("disp_0030", DISP, 7'd0, 7'd32, 1'b0);
    family_bits = 16'h0020;
    step("disp_0020", DISP, 7'd0, 7'd40, 1'b0);
    family_bits = 16'h8000;
    step("disp_8000", DISP, 7'd0, 7'd120, 1'b0);
    family_bits = 16'h0000;
    step("disp_none", DISP, 7'd0, 7'd104, 1'b0);
    evcond = 1'b0; family_bits = 16'h0080;
    step("disp_nopass", DISP, 7'd0, 7'd104, 1'b0);
    evcond = 1'b1;

    // Call/return, LIFO order, overflow and underflow traps.
    step("jump56", JUMP, 7'd56, 7'd56, 1'b0);
    step("call61", CALL, 7'd61, 7'd61, 1'b0);
    step("ret57", RET, 7'd0, 7'd57, 1'b0);
    step("call61b", CALL, 7'd61, 7'd61, 1'b0);
    step("call70", CALL, 7'd70, 7'd70, 1'b0);
    e_err = 1'b1;
    step("call_ovf", CALL, 7'd5, 7'd127, 1'b0);
    step("ret62", RET, 7'd0, 7'd62, 1'b0);
    step("ret58", RET, 7'd0, 7'd58, 1'b0);
    step("ret_unf", RET, 7'd0, 7'd127, 1'b0);

    // Memory wait, then abort flushing a non-empty stack.
    step("jump41", JUMP, 7'd41, 7'd41, 1'b0);
    mem_ready = 1'b0;
    step("wait1", WAIT, 7'd0, 7'd41, 1'b0);
    step("wait2", WAIT, 7'd0, 7'd41, 1'b0);
    step("wait3", WAIT, 7'd0, 7'd41, 1'b0);
    mem_ready = 1'b1;
    step("wait_rdy", WAIT, 7'd0, 7'd42, 1'b0);
    step("call41", CALL, 7'd41, 7'd41, 1'b0);
    mem_ready = 1'b0; abort = 1'b1;
    step("abort", WAIT, 7'd0, 7'd120, 1'b0);
    abort = 1'b0;
    step("ret_after_abort", RET, 7'd0, 7'd127, 1'b0);

    // Reset mid-operation with the stack non-empty clears everything.
    step("call9", CALL, 7'd9, 7'd9, 1'b0);
    do_reset();
    e_err = 1'b1;
    step("ret_after_reset", RET, 7'd0, 7'd127, 1'b0);
    do_reset();

    // IRQ vectoring only on FETCH; ack is a single-cycle pulse.
    irq = 1'b1;
    step("fetch_irq", FETCH, 7'd0, 7'd112, 1'b1);
    step("next_irq", NEXT, 7'd0, 7'd113, 1'b0);
    cond_sel = 3'd1; cond_vec = 8'h00; cond_inv = 1'b0;
    step("cbr_irq", CBR, 7'd20, 7'd114, 1'b0);
    step("fetch_irq2", FETCH, 7'd0, 7'd112, 1'b1);
    stall = 1'b1;
    step("stall_ack", FETCH, 7'd0, 7'd112, 1'b0);
    stall = 1'b0; irq = 1'b0;

    // Stall freezes a CALL; the stack is left untouched.
    step("jump10", JUMP, 7'd10, 7'd10, 1'b0);
    step("call20", CALL, 7'd20, 7'd20, 1'b0);
    stall = 1'b1;
    step("stall_call", CALL, 7'd30, 7'd20, 1'b0);
    stall = 1'b0;
    step("ret11", RET, 7'd0, 7'd11, 1'b0);
    e_err = 1'b1;
    step("ret_empty", RET, 7'd0, 7'd127, 1'b0);

    // Conditional branch with inversion, and increment wrap-around.
    cond_sel = 3'd2; cond_vec = 8'h04; cond_inv = 1'b1;
    step("cbr_inv", CBR, 7'd90, 7'd0, 1'b0);
    cond_inv = 1'b0;
    step("cbr_take", CBR, 7'd90, 7'd90, 1'b0);
    cond_vec = 8'hFB;
    step("cbr_clr", CBR, 7'd5, 7'd91, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
